// File: rtl/mealy_seq_det.sv
// Parametrised Mealy serial sequence detector with KMP transitions, overlap control,
// input enable, registered match flag and a saturating match counter.
module mealy_seq_det #(
    parameter int unsigned PAT_LEN = 4,
    parameter logic [15:0] PATTERN = 16'b1001,
    parameter bit          OVERLAP = 1'b1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             x,
    input  logic             clr_cnt,
    output logic             z,
    output logic             z_reg,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int unsigned SW = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;

    typedef logic [SW-1:0] state_t;

    // Longest pattern prefix (shorter than the full pattern) that is a suffix of the
    // first s pattern bits followed by b. Bit PAT_LEN-1 of PATTERN arrives first.
    function automatic int unsigned kmp_next(int unsigned s, logic b);
        logic [31:0] hist;
        logic [31:0] pre;
        logic [31:0] mask;
        int unsigned best;
        best = 0;
        hist = ((32'(PATTERN) >> (PAT_LEN - s)) << 1) | 32'(b);
        for (int unsigned k = 1; k <= s + 1; k++) begin
            mask = (32'd1 << k) - 32'd1;
            pre  = 32'(PATTERN) >> (PAT_LEN - k);
            if (k < PAT_LEN && (hist & mask) == (pre & mask)) begin
                best = k;
            end
        end
        return best;
    endfunction

    // Longest proper prefix of the pattern that is also a suffix of it.
    function automatic int unsigned border();
        logic [31:0] mask;
        int unsigned best;
        best = 0;
        for (int unsigned k = 1; k < PAT_LEN; k++) begin
            mask = (32'd1 << k) - 32'd1;
            if (((32'(PATTERN) >> (PAT_LEN - k)) & mask) == (32'(PATTERN) & mask)) begin
                best = k;
            end
        end
        return best;
    endfunction

    localparam state_t LAST_ST  = state_t'(PAT_LEN - 1);
    localparam state_t AFTER_ST = OVERLAP ? state_t'(border()) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t s_q, s_d;
    state_t nxt0 [2**SW];
    state_t nxt1 [2**SW];

    // Tables are padded to a power of two so the state register indexes them exactly.
    for (genvar g = 0; g < 2**SW; g++) begin : g_tbl
        if (g < PAT_LEN) begin : g_used
            assign nxt0[g] = state_t'(kmp_next(g, 1'b0));
            assign nxt1[g] = state_t'(kmp_next(g, 1'b1));
        end else begin : g_pad
            assign nxt0[g] = '0;
            assign nxt1[g] = '0;
        end
    end

    logic [CNT_W-1:0] cnt_d;
    logic             sat_d;

    assign z = ~reset & en & (s_q == LAST_ST) & (x == PATTERN[0]);

    always_comb begin
        s_d = s_q;
        if (en) begin
            if (z) begin
                s_d = AFTER_ST;
            end else if (x) begin
                s_d = nxt1[s_q];
            end else begin
                s_d = nxt0[s_q];
            end
        end
    end

    always_comb begin
        cnt_d = match_cnt;
        sat_d = cnt_sat;
        if (clr_cnt) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else begin
            if (z && match_cnt != CNT_MAX) begin
                cnt_d = match_cnt + 1'b1;
            end
            sat_d = cnt_sat | (cnt_d == CNT_MAX);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_q       <= '0;
            z_reg     <= 1'b0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else begin
            s_q       <= s_d;
            z_reg     <= z;
            match_cnt <= cnt_d;
            cnt_sat   <= sat_d;
        end
    end

endmodule

// File: tb/tb_mealy_seq_det.sv
// Bench for mealy_seq_det: five parameterisations driven by shared stimulus and
// checked every cycle against a bit-history window model, plus literal expectations.
module tb_mealy_seq_det;

    localparam int NI = 5;
    localparam int          LEN [NI] = '{4, 4, 4, 1, 6};
    localparam logic [15:0] PAT [NI] = '{16'h0009, 16'h0009, 16'h0009, 16'h0001, 16'h002D};
    localparam bit          OVL [NI] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam int          CW  [NI] = '{8, 8, 2, 3, 4};

    logic clk = 1'b0;
    logic reset, en, x, clr_cnt;

    logic        z_a   [NI];
    logic        zr_a  [NI];
    logic [31:0] cnt_a [NI];
    logic        sat_a [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [CW[g]-1:0] cnt;
        logic zz, zr, st;
        mealy_seq_det #(
            .PAT_LEN (LEN[g]),
            .PATTERN (PAT[g]),
            .OVERLAP (OVL[g]),
            .CNT_W   (CW[g])
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .en        (en),
            .x         (x),
            .clr_cnt   (clr_cnt),
            .z         (zz),
            .z_reg     (zr),
            .match_cnt (cnt),
            .cnt_sat   (st)
        );
        assign z_a[g]   = zz;
        assign zr_a[g]  = zr;
        assign cnt_a[g] = 32'(cnt);
        assign sat_a[g] = st;
    end

    always #5 clk = ~clk;

    int checks;
    int failures;

    // Model: last accepted bits (newest at LSB) and how many are valid since restart.
    logic [15:0] m_hist [NI];
    int          m_nv   [NI];
    int unsigned m_cnt  [NI];
    bit          m_sat  [NI];
    bit          m_zreg [NI];

    task automatic chk(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d actual=%0h expected=%0h", name, inst, act, exp);
        end
    endtask

    function automatic bit exp_z(int i);
        logic [15:0] mask, win;
        if (reset || !en) return 1'b0;
        mask = 16'((32'd1 << LEN[i]) - 32'd1);
        win  = (m_hist[i] << 1) | {15'd0, x};
        return (m_nv[i] + 1 >= LEN[i]) && ((win & mask) == (PAT[i] & mask));
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            chk("z", i, 32'(z_a[i]), 32'(exp_z(i)));
            chk("z_reg", i, 32'(zr_a[i]), reset ? 32'd0 : 32'(m_zreg[i]));
            chk("match_cnt", i, cnt_a[i], reset ? 32'd0 : m_cnt[i]);
            chk("cnt_sat", i, 32'(sat_a[i]), reset ? 32'd0 : 32'(m_sat[i]));
        end
    end

    always @(posedge clk) begin : upd
        bit ez;
        int unsigned mx;
        for (int i = 0; i < NI; i++) begin
            ez = exp_z(i);
            mx = (32'd1 << CW[i]) - 32'd1;
            if (reset) begin
                m_hist[i] = '0; m_nv[i] = 0; m_cnt[i] = 0; m_sat[i] = 1'b0; m_zreg[i] = 1'b0;
            end else begin
                if (clr_cnt) begin
                    m_cnt[i] = 0;
                    m_sat[i] = 1'b0;
                end else if (ez) begin
                    if (m_cnt[i] < mx) m_cnt[i]++;
                    if (m_cnt[i] == mx) m_sat[i] = 1'b1;
                end
                m_zreg[i] = ez;
                if (en) begin
                    if (ez && !OVL[i]) begin
                        m_nv[i] = 0;
                    end else begin
                        m_hist[i] = (m_hist[i] << 1) | {15'd0, x};
                        if (m_nv[i] < 16) m_nv[i]++;
                    end
                end
            end
        end
    end

    logic [NI-1:0] zs;

    task automatic step(input logic e, input logic b, input logic c);
        en = e; x = b; clr_cnt = c;
        @(negedge clk);
        for (int i = 0; i < NI; i++) zs[i] = z_a[i];
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        reset = 1'b0;
    endtask

    logic [17:0] s1;
    logic [17:0] v_ov, v_nov;
    logic [15:0] s5;

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; en = 1'b0; x = 1'b0; clr_cnt = 1'b0;
        for (int i = 0; i < NI; i++) begin
            m_hist[i] = '0; m_nv[i] = 0; m_cnt[i] = 0; m_sat[i] = 1'b0; m_zreg[i] = 1'b0;
        end
        repeat (2) step(1'b1, 1'b1, 1'b0);
        chk("lit_reset_z_p1", 3, 32'(zs[3]), 32'd0);
        reset = 1'b0;

        // Shared stream, first bit at MSB
        s1 = 18'b001001001010011001;
        for (int i = 0; i < 18; i++) begin
            step(1'b1, s1[17-i], 1'b0);
            v_ov[i]  = zs[0];
            v_nov[i] = zs[1];
        end
        chk("lit_ov_z_bits", 0, 32'(v_ov), 32'h22120);
        chk("lit_nov_z_bits", 1, 32'(v_nov), 32'h22020);
        chk("lit_ov_cnt", 0, cnt_a[0], 32'd4);
        chk("lit_nov_cnt", 1, cnt_a[1], 32'd3);
        chk("lit_sat_cnt4", 2, cnt_a[2], 32'd3);
        chk("lit_sat_flag4", 2, 32'(sat_a[2]), 32'd1);
        chk("lit_zreg_last", 0, 32'(zr_a[0]), 32'd1);

        // Enable gaps inside a pattern
        pulse_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("lit_en0_z", 0, 32'(zs[0]), 32'd0);
        step(1'b1, 1'b1, 1'b0);
        chk("lit_gap_match", 0, 32'(zs[0]), 32'd1);

        // Reset mid-pattern discards progress
        pulse_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        pulse_reset();
        step(1'b1, 1'b1, 1'b0);
        chk("lit_rst_nomatch", 0, 32'(zs[0]), 32'd0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("lit_rst_match", 0, 32'(zs[0]), 32'd1);

        // Five overlapping matches saturate a 2-bit counter, then clear beats a match
        pulse_reset();
        s5 = 16'b1001001001001001;
        for (int i = 0; i < 16; i++) step(1'b1, s5[15-i], 1'b0);
        chk("lit_sat_cnt5", 2, cnt_a[2], 32'd3);
        chk("lit_sat_flag5", 2, 32'(sat_a[2]), 32'd1);
        chk("lit_ov_cnt5", 0, cnt_a[0], 32'd5);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("lit_clr_z", 2, 32'(zs[2]), 32'd1);
        chk("lit_clr_cnt", 2, cnt_a[2], 32'd0);
        chk("lit_clr_sat", 2, 32'(sat_a[2]), 32'd0);

        // Single-bit pattern mirrors en & x
        step(1'b1, 1'b1, 1'b0);
        chk("lit_p1_hit", 3, 32'(zs[3]), 32'd1);
        step(1'b1, 1'b0, 1'b0);
        chk("lit_p1_miss", 3, 32'(zs[3]), 32'd0);
        step(1'b0, 1'b1, 1'b0);
        chk("lit_p1_en0", 3, 32'(zs[3]), 32'd0);

        repeat (3000) begin
            reset = ($urandom_range(0, 299) == 0);
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 63) == 0);
        end
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
